// File: rtl/door_actuator.sv
// door_actuator
//   Door mechanism sequencer. Drives the motor through open/close travel in
//   response to the door controller's commands and reverses a closing door
//   when an obstruction or open request is seen.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   openDoor     in   open request
//   closeDoor    in   close request
//   door_sensor  in   doorway obstruction, active-high
//   move_lock    in   car moving / not level; inhibits opening
//   door_state   out  1 only in OPEN (dwell-counter enable)
//   door_closed  out  1 only in CLOSED (car-motion interlock)
//   motor_open   out  1 only in OPENING
//   motor_close  out  1 only in CLOSING
//   position     out  0 = shut, TRAVEL_CYCLES = fully open
//   reopen_cnt   out  saturating count of CLOSING->OPENING reversals
//   fault        out  sticky: move_lock seen while not CLOSED
module door_actuator #(
  parameter int CNT_W         = 8,
  parameter int TRAVEL_CYCLES = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             openDoor,
  input  logic             closeDoor,
  input  logic             door_sensor,
  input  logic             move_lock,
  output logic             door_state,
  output logic             door_closed,
  output logic             motor_open,
  output logic             motor_close,
  output logic [CNT_W-1:0] position,
  output logic [3:0]       reopen_cnt,
  output logic             fault
);

  localparam logic [1:0] CLOSED  = 2'd0;
  localparam logic [1:0] OPENING = 2'd1;
  localparam logic [1:0] OPEN    = 2'd2;
  localparam logic [1:0] CLOSING = 2'd3;

  localparam logic [CNT_W-1:0] TRAVEL = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [3:0]       reopen_q, reopen_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    reopen_d = reopen_q;
    // Fault is only an indicator; it never alters sequencing.
    fault_d  = fault_q | (move_lock & (state_q != CLOSED));

    case (state_q)
      CLOSED: begin
        if (openDoor && !move_lock) state_d = OPENING;
      end
      OPENING: begin
        // >= rather than == : a reversal at full travel re-enters OPENING
        // with position already at TRAVEL, and must not overshoot.
        if (pos_q >= TRAVEL - ONE) begin
          pos_d   = TRAVEL;
          state_d = OPEN;
        end else begin
          pos_d = pos_q + ONE;
        end
      end
      OPEN: begin
        if (closeDoor && !openDoor && !door_sensor) state_d = CLOSING;
      end
      CLOSING: begin
        // Reversal wins over completion; position holds on the reversal edge.
        if (openDoor || door_sensor) begin
          state_d = OPENING;
          if (reopen_q != 4'hF) reopen_d = reopen_q + 4'd1;
        end else if (pos_q <= ONE) begin
          pos_d   = '0;
          state_d = CLOSED;
        end else begin
          pos_d = pos_q - ONE;
        end
      end
      default: begin
        state_d = CLOSED;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLOSED;
      pos_q    <= '0;
      reopen_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      reopen_q <= reopen_d;
      fault_q  <= fault_d;
    end
  end

  assign door_state  = (state_q == OPEN);
  assign door_closed = (state_q == CLOSED);
  assign motor_open  = (state_q == OPENING);
  assign motor_close = (state_q == CLOSING);
  assign position    = pos_q;
  assign reopen_cnt  = reopen_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_door_actuator.sv
module tb_door_actuator;
  localparam int CNT_W = 8;
  localparam int TC    = 4;

  logic             clk = 1'b0;
  logic             reset, openDoor, closeDoor, door_sensor, move_lock;
  logic             door_state, door_closed, motor_open, motor_close, fault;
  logic [CNT_W-1:0] position;
  logic [3:0]       reopen_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  door_actuator #(.CNT_W(CNT_W), .TRAVEL_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .openDoor(openDoor), .closeDoor(closeDoor),
    .door_sensor(door_sensor), .move_lock(move_lock),
    .door_state(door_state), .door_closed(door_closed),
    .motor_open(motor_open), .motor_close(motor_close),
    .position(position), .reopen_cnt(reopen_cnt), .fault(fault)
  );

  // Advance one edge; outputs sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Decoded state flags in order {door_state, door_closed, motor_open, motor_close}
  function automatic logic [31:0] flags();
    return {28'd0, door_state, door_closed, motor_open, motor_close};
  endfunction

  initial begin
    reset = 1'b1; openDoor = 1'b0; closeDoor = 1'b0;
    door_sensor = 1'b0; move_lock = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_flags", flags(), 32'b0100);
    chk("rst_pos", position, 0);
    chk("rst_reopen", reopen_cnt, 0);
    chk("rst_fault", fault, 0);

    // 1: open travel
    openDoor = 1'b1; tick(); openDoor = 1'b0;
    for (int i = 0; i < TC; i++) begin
      chk("opening_flags", flags(), 32'b0010);
      chk("opening_pos", position, i);
      tick();
    end
    chk("open_flags", flags(), 32'b1000);
    chk("open_pos", position, TC);

    // 2: close travel
    closeDoor = 1'b1; tick(); closeDoor = 1'b0;
    for (int i = 0; i < TC; i++) begin
      chk("closing_flags", flags(), 32'b0001);
      chk("closing_pos", position, TC - i);
      tick();
    end
    chk("closed_flags", flags(), 32'b0100);
    chk("closed_pos", position, 0);

    // 4a: move_lock inhibits opening, no fault while CLOSED
    openDoor = 1'b1; move_lock = 1'b1; tick(); tick();
    chk("lock_flags", flags(), 32'b0100);
    chk("lock_fault", fault, 0);
    openDoor = 1'b0; move_lock = 1'b0;

    // 3: reversal at position 2
    openDoor = 1'b1; tick(); openDoor = 1'b0;
    repeat (TC) tick();
    chk("reopen_open", flags(), 32'b1000);
    closeDoor = 1'b1; tick(); closeDoor = 1'b0;
    tick(); tick();
    chk("rev_pre_pos", position, 2);
    chk("rev_pre_flags", flags(), 32'b0001);
    door_sensor = 1'b1; tick(); door_sensor = 1'b0;
    chk("rev_flags", flags(), 32'b0010);
    chk("rev_pos", position, 2);
    chk("rev_cnt", reopen_cnt, 1);
    tick();
    chk("rev_pos3", position, 3);
    chk("rev_still_opening", flags(), 32'b0010);
    tick();
    chk("rev_open", flags(), 32'b1000);
    chk("rev_open_pos", position, TC);

    // 4b: move_lock in OPEN sets sticky fault, sequencing unaffected
    move_lock = 1'b1; tick(); move_lock = 1'b0;
    chk("fault_set", fault, 1);
    chk("fault_flags", flags(), 32'b1000);
    tick(); tick();
    chk("fault_sticky", fault, 1);

    // 5a: open and close together holds OPEN
    openDoor = 1'b1; closeDoor = 1'b1; tick(); tick();
    chk("both_flags", flags(), 32'b1000);
    chk("both_pos", position, TC);
    openDoor = 1'b0; closeDoor = 1'b0;
    door_sensor = 1'b1; closeDoor = 1'b1; tick();
    chk("sensor_hold", flags(), 32'b1000);
    door_sensor = 1'b0; closeDoor = 1'b0;
    chk("fault_still", fault, 1);

    // 5b: reset mid-OPENING
    closeDoor = 1'b1; tick(); closeDoor = 1'b0;
    repeat (TC) tick();
    chk("reclosed", flags(), 32'b0100);
    openDoor = 1'b1; tick(); openDoor = 1'b0;
    tick(); tick();
    chk("mid_pos", position, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_flags", flags(), 32'b0100);
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_reopen", reopen_cnt, 0);

    // 6: 17 reversals at full travel, counter saturates
    openDoor = 1'b1; tick(); openDoor = 1'b0;
    repeat (TC) tick();
    for (int k = 0; k < 17; k++) begin
      closeDoor = 1'b1; tick(); closeDoor = 1'b0;
      chk("sat_closing", flags(), 32'b0001);
      chk("sat_pos_c", position, TC);
      door_sensor = 1'b1; tick(); door_sensor = 1'b0;
      chk("sat_opening", flags(), 32'b0010);
      chk("sat_pos_o", position, TC);
      chk("sat_cnt", reopen_cnt, (k + 1 > 15) ? 15 : k + 1);
      tick();
      chk("sat_open", flags(), 32'b1000);
      chk("sat_pos_open", position, TC);
    end
    chk("sat_final", reopen_cnt, 15);

    // Reversal beats completion at position 1
    closeDoor = 1'b1; tick(); closeDoor = 1'b0;
    repeat (TC - 1) tick();
    chk("edge_pos1", position, 1);
    door_sensor = 1'b1; tick(); door_sensor = 1'b0;
    chk("edge_rev_flags", flags(), 32'b0010);
    chk("edge_rev_pos", position, 1);
    chk("edge_rev_cnt", reopen_cnt, 15);
    repeat (TC - 1) tick();
    chk("edge_open", flags(), 32'b1000);
    chk("edge_open_pos", position, TC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
